// File: rtl/bin_to_sseg.sv
// Sequential binary-to-seven-segment encoder for the calculator result path.
// A 20-bit magnitude is converted to six BCD digits with a shift-and-add-3
// engine (20 shifts), then encoded to active-low segment patterns with
// leading-zero blanking, a sign digit and an overflow display.
module bin_to_sseg (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] value,
  input  logic        neg,
  output logic [41:0] sseg_out,
  output logic [6:0]  sseg_sign,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] ENC  = 2'd2;

  localparam logic [6:0] SegMinus = 7'b1111110;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic [1:0]  state_q, state_d;
  logic [19:0] shreg_q, shreg_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        ovf_next_q, ovf_next_d;
  logic [41:0] sseg_q, sseg_d;
  logic [6:0]  sign_q, sign_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [23:0] bcd_adj;
  logic [41:0] sseg_enc;
  logic [6:0]  sign_enc;

  // Active-low segment pattern for one decimal digit, bit 6 = a.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more before shifting.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment encoding of the finished BCD value, with leading-zero blanking.
  always_comb begin
    logic lead;
    sseg_enc = '1;
    sign_enc = SegBlank;
    lead     = 1'b1;
    if (ovf_next_q) begin
      for (int i = 0; i < 6; i++) begin
        sseg_enc[7*i +: 7] = SegMinus;
      end
    end else begin
      // Walk from the top digit down; units digit is always shown.
      for (int i = 5; i >= 0; i--) begin
        lead = lead && (bcd_q[4*i +: 4] == 4'd0);
        if (lead && (i != 0)) begin
          sseg_enc[7*i +: 7] = SegBlank;
        end else begin
          sseg_enc[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
        end
      end
      if (neg_q && (bcd_q != 24'd0)) begin
        sign_enc = SegMinus;
      end
    end
  end

  // Next-state logic for the IDLE -> CONV -> ENC sequence.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    ovf_next_d = ovf_next_q;
    sseg_d     = sseg_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = value;
          bcd_d      = 24'd0;
          cnt_d      = 5'd0;
          neg_d      = neg;
          ovf_next_d = (value > 20'd999999);
          state_d    = CONV;
        end
      end
      CONV: begin
        {bcd_d, shreg_d} = {bcd_adj[22:0], shreg_q, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          state_d = ENC;
        end
      end
      ENC: begin
        sseg_d  = sseg_enc;
        sign_d  = sign_enc;
        ovf_d   = ovf_next_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset blanks the display and aborts conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= 20'd0;
      bcd_q      <= 24'd0;
      cnt_q      <= 5'd0;
      neg_q      <= 1'b0;
      ovf_next_q <= 1'b0;
      sseg_q     <= '1;
      sign_q     <= SegBlank;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      ovf_next_q <= ovf_next_d;
      sseg_q     <= sseg_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign sseg_out  = sseg_q;
  assign sseg_sign = sign_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
